// File: rtl/jingle_sched_if.sv
// Decoder-side key levels, player handshake and status outputs of the jingle scheduler.
interface jingle_if #(
  parameter int unsigned NUM_W = 3,
  parameter int unsigned VOL_W = 4,
  parameter int unsigned LVL_W = 3
);
  logic [NUM_W-1:0] num_i;
  logic             num_val_i;
  logic             vol_cntrl_i;
  logic             vol_cntrl_val_i;
  logic [NUM_W-1:0] play_num_o;
  logic             play_start_o;
  logic             play_busy_i;
  logic [VOL_W-1:0] vol_o;
  logic             drop_o;
  logic [LVL_W-1:0] q_level_o;

  modport slave (
    input  num_i, num_val_i, vol_cntrl_i, vol_cntrl_val_i, play_busy_i,
    output play_num_o, play_start_o, vol_o, drop_o, q_level_o
  );

  modport master (
    output num_i, num_val_i, vol_cntrl_i, vol_cntrl_val_i, play_busy_i,
    input  play_num_o, play_start_o, vol_o, drop_o, q_level_o
  );
endinterface

// File: rtl/jingle_sched.sv
// Queues decoder key presses into one-at-a-time jingle play requests and keeps a
// saturating volume register with typematic auto-repeat.
module jingle_sched #(
  parameter int unsigned JINGLE_CNT  = 8,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned VOL_W       = 4,
  parameter int unsigned VOL_INIT    = 8,
  parameter int unsigned REPEAT_DLY  = 16,
  parameter int unsigned REPEAT_PER  = 4,
  parameter int unsigned START_TO    = 64,
  parameter int unsigned GAP_CYC     = 8
) (
  input logic     clk_i,
  input logic     rst_i,
  jingle_if.slave bus
);
  localparam int unsigned NUM_W  = (JINGLE_CNT > 1) ? $clog2(JINGLE_CNT) : 1;
  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned TMR_MX = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
  localparam int unsigned TMR_W  = $clog2(TMR_MX + 1);
  localparam int unsigned RPT_W  = $clog2(REPEAT_DLY + 1);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_e;

  // Press detection and request FIFO
  logic [NUM_W-1:0] prev_num_q;
  logic             prev_val_q;
  logic [NUM_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_req, push_ok, pop, full;

  // Playback sequencer
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [NUM_W-1:0] play_num_q, play_num_d;
  logic             play_start_q, play_start_d;
  logic             drop_q, drop_d;
  logic             timeout;

  // Volume
  logic             vprev_val_q, vprev_dir_q;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             vedge, vstep;

  always_comb begin
    push_req = bus.num_val_i && (!prev_val_q || (bus.num_i != prev_num_q))
               && (32'(bus.num_i) < JINGLE_CNT);
    full     = (level_q == LVL_W'(QUEUE_DEPTH));
    pop      = (state_q == IDLE) && (level_q != '0);
    // a pop in the same cycle frees the slot a push into a full queue needs
    push_ok  = push_req && (!full || pop);
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: begin
        if (bus.play_busy_i) begin
          state_d = PLAY;
        end else if (timer_q == TMR_W'(START_TO - 1)) begin
          timeout = 1'b1;
          state_d = GAP;
        end
      end
      PLAY:  if (!bus.play_busy_i) state_d = GAP;
      GAP:   if (timer_q == TMR_W'(GAP_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    timer_d = '0;
    if ((state_d == state_q) && ((state_q == START) || (state_q == GAP))) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // start is raised one cycle after entering START and dropped as soon as busy is seen
    play_start_d = (state_q == START) && (state_d == START);
    play_num_d   = pop ? mem_q[rd_ptr_q] : play_num_q;
    drop_d       = timeout || (push_req && !push_ok);
  end

  always_comb begin
    vedge = bus.vol_cntrl_val_i &&
            (!vprev_val_q || (bus.vol_cntrl_i != vprev_dir_q));
    vstep = 1'b0;
    rpt_d = '0;
    if (vedge) begin
      vstep = 1'b1;
      rpt_d = RPT_W'(1);
    end else if (bus.vol_cntrl_val_i) begin
      // after the initial delay the counter is rewound so it re-hits REPEAT_DLY every REPEAT_PER
      if (rpt_q == RPT_W'(REPEAT_DLY)) begin
        vstep = 1'b1;
        rpt_d = RPT_W'(REPEAT_DLY - REPEAT_PER + 1);
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end

    vol_d = vol_q;
    if (vstep) begin
      if (bus.vol_cntrl_i) begin
        if (vol_q != '1) vol_d = vol_q + VOL_W'(1);
      end else begin
        if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.num_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_num_q   <= '0;
      prev_val_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      timer_q      <= '0;
      play_num_q   <= '0;
      play_start_q <= 1'b0;
      drop_q       <= 1'b0;
      vprev_val_q  <= 1'b0;
      vprev_dir_q  <= 1'b0;
      rpt_q        <= '0;
      vol_q        <= VOL_W'(VOL_INIT);
    end else begin
      prev_num_q   <= bus.num_i;
      prev_val_q   <= bus.num_val_i;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      level_q <= level_q + LVL_W'(1);
      else if (!push_ok && pop) level_q <= level_q - LVL_W'(1);
      state_q      <= state_d;
      timer_q      <= timer_d;
      play_num_q   <= play_num_d;
      play_start_q <= play_start_d;
      drop_q       <= drop_d;
      vprev_val_q  <= bus.vol_cntrl_val_i;
      vprev_dir_q  <= bus.vol_cntrl_i;
      rpt_q        <= rpt_d;
      vol_q        <= vol_d;
    end
  end

  assign bus.play_num_o   = play_num_q;
  assign bus.play_start_o = play_start_q;
  assign bus.vol_o        = vol_q;
  assign bus.drop_o       = drop_q;
  assign bus.q_level_o    = level_q;
endmodule
